exception_sequencer: RTL and testbench

Multicycle exception controller for the 64-bit RISC-V datapath. It watches the control unit's overflow and illegal-opcode events and holds the control unit while it works. It saves the faulting PC into its own EPC register and drives the instruction-memory address select toward the handler vector word (0xFF = illegal, 0xFE = overflow). It then loads the PC with the fetched vector and releases the control unit with a restart pulse.

---
 rtl/exception_pkg.sv | 19 +
 rtl/exception_sequencer.sv | 92 +++++++++
 tb/tb_exception_sequencer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/exception_pkg.sv
// Shared definitions for the exception sequencer and the datapath muxes it steers.
package exception_pkg;

  typedef enum logic [1:0] {
    EXC_IDLE      = 2'd0,
    EXC_FETCH_VEC = 2'd1,
    EXC_LOAD_PC   = 2'd2,
    EXC_DONE      = 2'd3
  } exc_state_t;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_OVF     = 2'd2;

  // Word addresses the datapath selects on src_exc=1/2.
  localparam logic [31:0] VEC_ADDR_ILLEGAL = 32'hFF;
  localparam logic [31:0] VEC_ADDR_OVF     = 32'hFE;

endpackage

// File: rtl/exception_sequencer.sv
// Multicycle exception controller: saves EPC, fetches the handler vector word,
// loads it into the PC and restarts the control unit.
module exception_sequencer
  import exception_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int PC_W    = 64,
  parameter int VEC_W   = 8
) (
  input  logic            clk,
  input  logic            Reset,
  input  logic            exc_en,
  input  logic            ovf_evt,
  input  logic            illegal_evt,
  input  logic [PC_W-1:0] pc_in,
  input  logic [31:0]     imem_dout,
  output logic [1:0]      src_exc,
  output logic            uc_hold,
  output logic            pc_load,
  output logic [PC_W-1:0] pc_next,
  output logic            uc_restart,
  output logic [PC_W-1:0] epc,
  output logic [1:0]      cause,
  output logic            exc_lost,
  output logic [15:0]     exc_count
);

  localparam logic [1:0] IDLE      = 2'(EXC_IDLE);
  localparam logic [1:0] FETCH_VEC = 2'(EXC_FETCH_VEC);
  localparam logic [1:0] LOAD_PC   = 2'(EXC_LOAD_PC);
  localparam logic [1:0] DONE      = 2'(EXC_DONE);

  localparam logic [2:0] CNT_INIT = 3'(MEM_LAT - 1);

  logic [1:0] state;
  logic [2:0] waitCnt;
  logic       evtTaken;
  logic       unusedImemBits;

  assign evtTaken       = exc_en & (ovf_evt | illegal_evt);
  assign unusedImemBits = ^imem_dout[31:VEC_W];

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples pre-edge values; the async reset clears even a sequence in flight.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      pc_next   <= '0;
      epc       <= '0;
      cause     <= CAUSE_NONE;
      exc_lost  <= 1'b0;
      exc_count <= 16'd0;
    end else begin
      if (evtTaken && state != IDLE) exc_lost <= 1'b1;
      case (state)
        IDLE: begin
          if (evtTaken) begin
            epc       <= pc_in - PC_W'(4);
            cause     <= illegal_evt ? CAUSE_ILLEGAL : CAUSE_OVF;
            exc_count <= exc_count + 16'd1;
            state     <= FETCH_VEC;
          end
        end
        FETCH_VEC: begin
          if (waitCnt == 3'd0) begin
            pc_next <= PC_W'(imem_dout[VEC_W-1:0]);
            state   <= LOAD_PC;
          end
        end
        LOAD_PC: state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  // Counts down the instruction-memory latency while the vector address is held.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      waitCnt <= 3'd0;
    end else if (state == IDLE && evtTaken) begin
      waitCnt <= CNT_INIT;
    end else if (state == FETCH_VEC && waitCnt != 3'd0) begin
      waitCnt <= waitCnt - 3'd1;
    end
  end

  assign src_exc    = (state == FETCH_VEC || state == LOAD_PC) ? cause : CAUSE_NONE;
  assign uc_hold    = (state != IDLE);
  assign pc_load    = (state == LOAD_PC);
  assign uc_restart = (state == DONE);

endmodule

// File: tb/tb_exception_sequencer.sv
// Self-checking bench: cycle vectors with a scoreboard for MEM_LAT=1 and MEM_LAT=3.
module tb_exception_sequencer;

  typedef struct {
    logic [1:0]  src;
    logic        hold;
    logic        load;
    logic        restart;
    logic [63:0] pcNext;
    logic [63:0] epc;
    logic [1:0]  cause;
    logic        lost;
    logic [15:0] cnt;
  } exp_t;

  typedef struct {
    logic        en;
    logic        ovf;
    logic        ill;
    logic [63:0] pc;
    exp_t        e;
  } vec_t;

  localparam logic [63:0] EPC_WRAP = 64'hFFFF_FFFF_FFFF_FFFC;

  logic        clk = 1'b0;
  logic        Reset;
  logic        excEn, ovfEvt, illEvt;
  logic [63:0] pcIn;
  logic [31:0] dout1, dout3;

  logic [1:0]  src1, cause1, src3, cause3;
  logic        hold1, load1, rst1, lost1, hold3, load3, rst3, lost3;
  logic [63:0] pcn1, epc1, pcn3, epc3;
  logic [15:0] cnt1, cnt3;

  logic [1:0]  hist0, hist1;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  vec_t tbl[19];

  always #5 clk = ~clk;

  exception_sequencer #(.MEM_LAT(1)) d1 (
    .clk(clk), .Reset(Reset), .exc_en(excEn), .ovf_evt(ovfEvt), .illegal_evt(illEvt),
    .pc_in(pcIn), .imem_dout(dout1), .src_exc(src1), .uc_hold(hold1), .pc_load(load1),
    .pc_next(pcn1), .uc_restart(rst1), .epc(epc1), .cause(cause1), .exc_lost(lost1),
    .exc_count(cnt1)
  );

  exception_sequencer #(.MEM_LAT(3)) d3 (
    .clk(clk), .Reset(Reset), .exc_en(excEn), .ovf_evt(ovfEvt), .illegal_evt(illEvt),
    .pc_in(pcIn), .imem_dout(dout3), .src_exc(src3), .uc_hold(hold3), .pc_load(load3),
    .pc_next(pcn3), .uc_restart(rst3), .epc(epc3), .cause(cause3), .exc_lost(lost3),
    .exc_count(cnt3)
  );

  // Instruction memory for d1: data follows the address combinationally.
  always_comb begin
    case (src1)
      2'd1:    dout1 = 32'hDEAD_BE40;
      2'd2:    dout1 = 32'hCAFE_00A8;
      default: dout1 = 32'h0000_0013;
    endcase
  end

  // Instruction memory for d3: data reflects the address two cycles earlier.
  always @(posedge clk) begin
    hist0 <= src3;
    hist1 <= hist0;
  end

  always_comb begin
    case (hist1)
      2'd1:    dout3 = 32'h0000_0040;
      2'd2:    dout3 = 32'h0000_00A8;
      default: dout3 = 32'h0000_0013;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic vec_t mkVec(input logic en, input logic ovf, input logic ill,
                                 input logic [63:0] pc, input logic [1:0] src,
                                 input logic hold, input logic load, input logic restart,
                                 input logic [63:0] pcNext, input logic [63:0] epc,
                                 input logic [1:0] cause, input logic lost,
                                 input logic [15:0] cnt);
    vec_t v;
    v.en = en; v.ovf = ovf; v.ill = ill; v.pc = pc;
    v.e.src = src; v.e.hold = hold; v.e.load = load; v.e.restart = restart;
    v.e.pcNext = pcNext; v.e.epc = epc; v.e.cause = cause; v.e.lost = lost; v.e.cnt = cnt;
    return v;
  endfunction

  task automatic compareOut(input string tag, input exp_t e, input bit onD3);
    if (!onD3) begin
      check({tag, ".src_exc"}, 64'(src1), 64'(e.src));
      check({tag, ".uc_hold"}, 64'(hold1), 64'(e.hold));
      check({tag, ".pc_load"}, 64'(load1), 64'(e.load));
      check({tag, ".uc_restart"}, 64'(rst1), 64'(e.restart));
      check({tag, ".pc_next"}, pcn1, e.pcNext);
      check({tag, ".epc"}, epc1, e.epc);
      check({tag, ".cause"}, 64'(cause1), 64'(e.cause));
      check({tag, ".exc_lost"}, 64'(lost1), 64'(e.lost));
      check({tag, ".exc_count"}, 64'(cnt1), 64'(e.cnt));
    end else begin
      check({tag, ".src_exc"}, 64'(src3), 64'(e.src));
      check({tag, ".uc_hold"}, 64'(hold3), 64'(e.hold));
      check({tag, ".pc_load"}, 64'(load3), 64'(e.load));
      check({tag, ".uc_restart"}, 64'(rst3), 64'(e.restart));
      check({tag, ".pc_next"}, pcn3, e.pcNext);
      check({tag, ".epc"}, epc3, e.epc);
      check({tag, ".cause"}, 64'(cause3), 64'(e.cause));
      check({tag, ".exc_lost"}, 64'(lost3), 64'(e.lost));
      check({tag, ".exc_count"}, 64'(cnt3), 64'(e.cnt));
    end
  endtask

  // Drive one cycle of inputs, queue the expectation, compare just after the edge.
  task automatic applyVec(input vec_t v, input bit onD3, input string tag);
    exp_t got;
    excEn = v.en; ovfEvt = v.ovf; illEvt = v.ill; pcIn = v.pc;
    sb.push_back(v.e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    compareOut(tag, got, onD3);
  endtask

  task automatic idleInputs();
    excEn = 1'b1; ovfEvt = 1'b0; illEvt = 1'b0; pcIn = 64'h0;
  endtask

  task automatic takeExcD1();
    excEn = 1'b1; illEvt = 1'b1; ovfEvt = 1'b0; pcIn = 64'h104;
    @(posedge clk); #1;
    idleInputs();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t zero;
    vec_t v;
    zero = '{src: 2'd0, hold: 1'b0, load: 1'b0, restart: 1'b0, pcNext: 64'h0,
             epc: 64'h0, cause: 2'd0, lost: 1'b0, cnt: 16'h0};

    //                en ovf ill pc          src hold load rst pcNext  epc       cause lost cnt
    tbl[0]  = mkVec(1, 0, 1, 64'h104, 1, 1, 0, 0, 64'h00, 64'h100, 1, 0, 1);
    tbl[1]  = mkVec(1, 0, 0, 64'h108, 1, 1, 1, 0, 64'h40, 64'h100, 1, 0, 1);
    tbl[2]  = mkVec(1, 0, 0, 64'h108, 0, 1, 0, 1, 64'h40, 64'h100, 1, 0, 1);
    tbl[3]  = mkVec(1, 0, 0, 64'h108, 0, 0, 0, 0, 64'h40, 64'h100, 1, 0, 1);
    tbl[4]  = mkVec(1, 1, 1, 64'h208, 1, 1, 0, 0, 64'h40, 64'h204, 1, 0, 2);
    tbl[5]  = mkVec(1, 0, 0, 64'h000, 1, 1, 1, 0, 64'h40, 64'h204, 1, 0, 2);
    tbl[6]  = mkVec(1, 0, 0, 64'h000, 0, 1, 0, 1, 64'h40, 64'h204, 1, 0, 2);
    tbl[7]  = mkVec(1, 0, 0, 64'h000, 0, 0, 0, 0, 64'h40, 64'h204, 1, 0, 2);
    tbl[8]  = mkVec(1, 1, 0, 64'h000, 2, 1, 0, 0, 64'h40, EPC_WRAP, 2, 0, 3);
    tbl[9]  = mkVec(1, 0, 0, 64'h004, 2, 1, 1, 0, 64'hA8, EPC_WRAP, 2, 0, 3);
    tbl[10] = mkVec(1, 1, 0, 64'h500, 0, 1, 0, 1, 64'hA8, EPC_WRAP, 2, 1, 3);
    tbl[11] = mkVec(1, 0, 0, 64'h500, 0, 0, 0, 0, 64'hA8, EPC_WRAP, 2, 1, 3);
    tbl[12] = mkVec(0, 0, 1, 64'h300, 0, 0, 0, 0, 64'hA8, EPC_WRAP, 2, 1, 3);
    tbl[13] = mkVec(0, 1, 0, 64'h300, 0, 0, 0, 0, 64'hA8, EPC_WRAP, 2, 1, 3);
    tbl[14] = mkVec(1, 0, 1, 64'h404, 1, 1, 0, 0, 64'hA8, 64'h400, 1, 1, 4);
    tbl[15] = mkVec(1, 1, 0, 64'h700, 1, 1, 1, 0, 64'h40, 64'h400, 1, 1, 4);
    tbl[16] = mkVec(1, 0, 0, 64'h000, 0, 1, 0, 1, 64'h40, 64'h400, 1, 1, 4);
    tbl[17] = mkVec(1, 1, 0, 64'h600, 0, 0, 0, 0, 64'h40, 64'h400, 1, 1, 4);
    tbl[18] = mkVec(1, 0, 0, 64'h000, 0, 0, 0, 0, 64'h40, 64'h400, 1, 1, 4);

    Reset = 1'b0;
    excEn = 1'b0; ovfEvt = 1'b0; illEvt = 1'b0; pcIn = 64'h0;
    #3;
    compareOut("reset_d1", zero, 1'b0);
    compareOut("reset_d3", zero, 1'b1);
    #9 Reset = 1'b1;

    for (int i = 0; i < 19; i++) begin
      applyVec(tbl[i], 1'b0, $sformatf("lat1_v%0d", i));
    end

    // MEM_LAT=3 overflow with an illegal event arriving mid-fetch.
    idleInputs();
    Reset = 1'b0;
    #1 Reset = 1'b1;
    applyVec(mkVec(1, 1, 0, 64'h020, 2, 1, 0, 0, 64'h00, 64'h1C, 2, 0, 1), 1'b1, "lat3_s0");
    applyVec(mkVec(1, 0, 1, 64'h900, 2, 1, 0, 0, 64'h00, 64'h1C, 2, 1, 1), 1'b1, "lat3_s1");
    applyVec(mkVec(1, 0, 0, 64'h000, 2, 1, 0, 0, 64'h00, 64'h1C, 2, 1, 1), 1'b1, "lat3_s2");
    applyVec(mkVec(1, 0, 0, 64'h000, 2, 1, 1, 0, 64'hA8, 64'h1C, 2, 1, 1), 1'b1, "lat3_s3");
    applyVec(mkVec(1, 0, 0, 64'h000, 0, 1, 0, 1, 64'hA8, 64'h1C, 2, 1, 1), 1'b1, "lat3_s4");
    applyVec(mkVec(1, 0, 0, 64'h000, 0, 0, 0, 0, 64'hA8, 64'h1C, 2, 1, 1), 1'b1, "lat3_s5");

    // Asynchronous reset in the first FETCH_VEC cycle.
    applyVec(mkVec(1, 1, 0, 64'h044, 2, 1, 0, 0, 64'hA8, 64'h40, 2, 1, 2), 1'b1, "rstmid_evt");
    idleInputs();
    #1 Reset = 1'b0;
    #1 compareOut("rstmid_async", zero, 1'b1);
    #1 Reset = 1'b1;
    v = mkVec(1, 0, 0, 64'h0, 0, 0, 0, 0, 64'h0, 64'h0, 0, 0, 0);
    applyVec(v, 1'b1, "rstmid_idle");
    applyVec(v, 1'b1, "rstmid_idle2");

    // Counter wrap: preload near the top, then take two exceptions.
    force d1.exc_count = 16'hFFFE;
    #1 release d1.exc_count;
    takeExcD1();
    check("wrap_ffff", 64'(cnt1), 64'hFFFF);
    takeExcD1();
    check("wrap_zero", 64'(cnt1), 64'h0000);
    check("wrap_epc", epc1, 64'h100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
